// File: rtl/btn_evt_queue.sv
`default_nettype none
// ============================================================================
// Module   : btn_evt_queue
// Purpose  : Expands every changed, enabled button of a report into one event
//            byte, queues the bytes in a FIFO and counts dropped/merged events.
// Revision : 1.0 - initial release
// ============================================================================
module btn_evt_queue #(
   parameter int                 N_BTN      = 16,
   parameter int                 FIFO_DEPTH = 8,
   parameter int                 MODE       = 0,
   parameter logic [8*N_BTN-1:0] CHARS      = "DULRABSMEFGHIJKL"
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] rpt_state,
   input  logic [N_BTN-1:0] rpt_change,
   input  logic             rpt_stb,
   input  logic [N_BTN-1:0] en_mask,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ack,
   output logic [7:0]       ovf_cnt,
   input  logic             ovf_clr,
   output logic             busy
);

   localparam int c_IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
   localparam int c_AW    = $clog2(FIFO_DEPTH);
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_BTN - 1);
   localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
   localparam logic [c_AW:0]      c_PTR_ONE  = (c_AW + 1)'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SCAN = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_IDX_W-1:0] r_idx;
   logic [c_IDX_W-1:0] w_idx_nxt;
   logic [N_BTN-1:0]   r_pending;
   logic [N_BTN-1:0]   r_snap;
   logic [N_BTN-1:0]   w_new;
   logic [N_BTN-1:0]   w_emit_mask;
   logic [N_BTN-1:0]   w_pending_nxt;
   logic               w_emit;
   logic               w_coalesce;
   logic [7:0]         w_evt;

   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;

   logic [7:0]         r_ovf_cnt;
   logic [1:0]         w_inc;
   logic [8:0]         w_ovf_sum;
   logic [7:0]         w_ovf_nxt;

   assign w_new  = rpt_stb ? (rpt_change & en_mask) : '0;
   assign w_emit = (r_state == S_SCAN) && r_pending[r_idx];

   always_comb begin
      w_emit_mask = '0;
      for (int i = 0; i < N_BTN; i++) begin
         w_emit_mask[i] = w_emit && (r_idx == c_IDX_W'(i));
      end
   end

   // A report bit landing on the slot being emitted re-arms it rather than merging.
   assign w_coalesce    = |(w_new & r_pending & ~w_emit_mask);
   assign w_pending_nxt = (r_pending & ~w_emit_mask) | w_new;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_pending_nxt != '0) begin
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (w_pending_nxt != '0) begin
               w_state_nxt = S_SCAN;
               w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   generate
      if (MODE == 0) begin : g_ascii
         logic [7:0] w_chars [N_BTN];
         for (genvar g = 0; g < N_BTN; g++) begin : g_char
            assign w_chars[g] = CHARS[8*(N_BTN-1-g) +: 8];
         end
         assign w_evt = r_snap[r_idx] ? w_chars[r_idx] : (w_chars[r_idx] | 8'h20);
      end else begin : g_binary
         assign w_evt = {r_snap[r_idx], 7'(r_idx)};
      end
   endgenerate

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop   = out_ack && !w_empty;
   // A full FIFO still accepts the event when the head leaves on the same edge.
   assign w_push  = w_emit && (!w_full || w_pop);
   assign w_drop  = w_emit && !w_push;

   assign w_inc     = {1'b0, w_drop} + {1'b0, w_coalesce};
   assign w_ovf_sum = {1'b0, r_ovf_cnt} + {7'b0, w_inc};
   assign w_ovf_nxt = ovf_clr      ? 8'h00 :
                      w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_snap    <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_ovf_cnt <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         r_snap    <= (r_snap & ~w_new) | (rpt_state & w_new);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         r_ovf_cnt <= w_ovf_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= w_evt;
      end
   end

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];
   assign ovf_cnt   = r_ovf_cnt;
   assign busy      = (r_state == S_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_btn_evt_queue.sv
`default_nettype none
// tb_btn_evt_queue: ASCII and binary instances share one stimulus stream; a
// scoreboard of expected byte pairs is filled by a reference model and drained by a monitor.
module tb_btn_evt_queue;
   localparam int N     = 16;
   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] rpt_state, rpt_change, en_mask;
   logic         rpt_stb, out_ack, ovf_clr;
   logic [7:0]   data_a, data_b, ovf_a, ovf_b;
   logic         valid_a, valid_b, busy_a, busy_b;

   btn_evt_queue #(.N_BTN(N), .FIFO_DEPTH(DEPTH), .MODE(0), .CHARS("DULRABSMEFGHIJKL")) dut_a (
      .clk(clk), .rst_n(rst_n), .rpt_state(rpt_state), .rpt_change(rpt_change),
      .rpt_stb(rpt_stb), .en_mask(en_mask), .out_data(data_a), .out_valid(valid_a),
      .out_ack(out_ack), .ovf_cnt(ovf_a), .ovf_clr(ovf_clr), .busy(busy_a));

   btn_evt_queue #(.N_BTN(N), .FIFO_DEPTH(DEPTH), .MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rpt_state(rpt_state), .rpt_change(rpt_change),
      .rpt_stb(rpt_stb), .en_mask(en_mask), .out_data(data_b), .out_valid(valid_b),
      .out_ack(out_ack), .ovf_cnt(ovf_b), .ovf_clr(ovf_clr), .busy(busy_b));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a set of armed buttons with latched states, a scan
   // position, an occupancy count and a list of expected {ascii, binary} bytes.
   bit          m_pend [N];
   bit          m_snap [N];
   int          m_pos, m_cnt, m_ovf;
   logic [15:0] exp_q [$];
   string       chars = "DULRABSMEFGHIJKL";

   function automatic logic [7:0] enc_ascii(input int i, input bit pressed);
      logic [7:0] c;
      c = chars[i];
      return pressed ? c : (c | 8'h20);
   endfunction

   function automatic logic [7:0] enc_bin(input int i, input bit pressed);
      return 8'((pressed ? 128 : 0) + i);
   endfunction

   function automatic bit any_pend();
      for (int i = 0; i < N; i++) if (m_pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model_step
      bit active, emitting, pop, coal;
      int extra;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_snap[i] = 1'b0;
         end
         m_pos = 0; m_cnt = 0; m_ovf = 0;
         exp_q.delete();
      end else begin
         active   = any_pend();
         emitting = active && m_pend[m_pos];
         pop      = out_ack && (m_cnt > 0);
         extra    = 0;
         if (emitting) begin
            if (m_cnt < DEPTH || pop) begin
               exp_q.push_back({enc_ascii(m_pos, m_snap[m_pos]), enc_bin(m_pos, m_snap[m_pos])});
               m_cnt++;
            end else begin
               extra++;
            end
            m_pend[m_pos] = 1'b0;
         end
         if (pop) m_cnt--;
         if (rpt_stb) begin
            coal = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (rpt_change[i] && en_mask[i]) begin
                  if (m_pend[i]) coal = 1'b1;
                  m_pend[i] = 1'b1;
                  m_snap[i] = rpt_state[i];
               end
            end
            if (coal) extra++;
         end
         if (!any_pend())  m_pos = 0;
         else if (active)  m_pos = (m_pos + 1) % N;
         if (ovf_clr) m_ovf = 0;
         else         m_ovf = (m_ovf + extra > 255) ? 255 : m_ovf + extra;
      end
   end

   // Monitor: compares every visible output against the model once per cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         check("valid_a", 32'(valid_a), 32'(m_cnt > 0));
         check("valid_b", 32'(valid_b), 32'(m_cnt > 0));
         check("busy_a",  32'(busy_a),  32'(any_pend()));
         check("busy_b",  32'(busy_b),  32'(any_pend()));
         check("ovf_a",   32'(ovf_a),   32'(m_ovf));
         check("ovf_b",   32'(ovf_b),   32'(m_ovf));
         if (valid_a && exp_q.size() > 0) begin
            check("head_ascii",  32'(data_a), 32'(exp_q[0][15:8]));
            check("head_binary", 32'(data_b), 32'(exp_q[0][7:0]));
            if (out_ack) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic report(input logic [N-1:0] chg, input logic [N-1:0] st);
      rpt_change = chg;
      rpt_state  = st;
      rpt_stb    = 1'b1;
      tick();
      rpt_stb    = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (busy_a && k < 200) begin
         tick();
         k++;
      end
      check({name, "_idle_timeout"}, 32'(busy_a), 32'd0);
   endtask

   task automatic drain_check(input string name, input int n, input logic [63:0] bytes);
      for (int k = 0; k < n; k++) begin
         check({name, "_valid"}, 32'(valid_a), 32'd1);
         check({name, "_data"},  32'(data_a),  32'(bytes[8*(n-1-k) +: 8]));
         out_ack = 1'b1;
         tick();
         out_ack = 1'b0;
      end
      check({name, "_empty"}, 32'(valid_a), 32'd0);
   endtask

   task automatic clear_ovf();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0; rpt_state = '0; rpt_change = '0; rpt_stb = 1'b0;
      en_mask = '1; out_ack = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_data",  32'(data_a),  32'd0);
      check("rst_ovf",   32'(ovf_a),   32'd0);
      check("rst_busy",  32'(busy_b),  32'd0);
      rst_n = 1'b1;
      tick();

      // Two changes, empty FIFO, no ack
      report(16'h0005, 16'h0001);
      check("t1_valid_e0", 32'(valid_a), 32'd0);
      check("t1_busy_e0",  32'(busy_a),  32'd1);
      tick();
      check("t1_valid_e1", 32'(valid_a), 32'd1);
      check("t1_data_e1",  32'(data_a),  32'h44);
      check("t1_bin_e1",   32'(data_b),  32'h80);
      tick();
      check("t1_busy_e2",  32'(busy_a),  32'd1);
      tick();
      check("t1_busy_e3",  32'(busy_a),  32'd0);
      check("t1_ovf",      32'(ovf_a),   32'd0);
      drain_check("t1", 2, 64'h446C);

      // Enable mask
      en_mask = 16'hFFFE;
      report(16'h0003, 16'h0003);
      wait_idle("t2");
      check("t2_ovf", 32'(ovf_a), 32'd0);
      drain_check("t2", 1, 64'h55);
      en_mask = '1;

      // FIFO overflow
      report(16'h03FF, 16'h03FF);
      wait_idle("t3");
      check("t3_ovf",  32'(ovf_a),  32'd2);
      check("t3_busy", 32'(busy_a), 32'd0);
      drain_check("t3", 8, "DULRABSM");
      clear_ovf();
      check("t3_ovf_clr", 32'(ovf_a), 32'd0);

      // Coalesce on a pending, not-yet-scanned bit
      report(16'hC000, 16'hC000);
      tick();
      report(16'h8000, 16'h0000);
      wait_idle("t4");
      check("t4_ovf", 32'(ovf_a), 32'd1);
      drain_check("t4", 2, 64'h4B6C);
      clear_ovf();

      // Binary encoding, handshake, clear beats increment
      report(16'h0010, 16'h0010);
      wait_idle("t5");
      check("t5_valid_b", 32'(valid_b), 32'd1);
      check("t5_data_b",  32'(data_b),  32'h84);
      check("t5_data_a",  32'(data_a),  32'h41);
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      check("t5_valid_after_ack", 32'(valid_b), 32'd0);
      report(16'h8000, 16'h8000);
      report(16'h8000, 16'h8000);
      check("t5_ovf_inc", 32'(ovf_a), 32'd1);
      ovf_clr = 1'b1;
      report(16'h8000, 16'h8000);
      ovf_clr = 1'b0;
      check("t5_ovf_clr_wins_a", 32'(ovf_a), 32'd0);
      check("t5_ovf_clr_wins_b", 32'(ovf_b), 32'd0);
      wait_idle("t5b");
      drain_check("t5", 1, 64'h4C);

      // Asynchronous reset in the middle of a scan
      report(16'hFFFF, 16'h5A5A);
      report(16'hFFFF, 16'h5A5A);
      tick();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6_valid_async", 32'(valid_a), 32'd0);
      check("t6_busy_async",  32'(busy_a),  32'd0);
      check("t6_ovf_async",   32'(ovf_a),   32'd0);
      check("t6_valid_b",     32'(valid_b), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (30) tick();
      check("t6_no_evt_valid", 32'(valid_a), 32'd0);
      check("t6_no_evt_busy",  32'(busy_a),  32'd0);

      // Randomized traffic: slow consumer first, then a fast one
      for (int c = 0; c < 2500; c++) begin
         rpt_stb    = ($urandom_range(0, 5) == 0);
         rpt_change = 16'($urandom);
         rpt_state  = 16'($urandom);
         en_mask    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '1;
         out_ack    = (c < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         ovf_clr    = ($urandom_range(0, 49) == 0);
         tick();
      end
      rpt_stb = 1'b0;
      ovf_clr = 1'b0;
      out_ack = 1'b1;
      k = 0;
      while ((busy_a || valid_a) && k < 500) begin
         tick();
         k++;
      end
      out_ack = 1'b0;
      check("final_drain_timeout", 32'(busy_a || valid_a), 32'd0);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/btn_evt_queue.md
Name: btn_evt_queue

Overview:
Parametrised successor to the single-event button-to-UART data generator. It takes button state/change reports from the SPI F4 command decoder and expands every changed, enabled button into one event byte. Events are buffered in a FIFO and presented on a valid/ack byte interface that drives uart_tx directly. Unlike the single-event generator, it never loses simultaneous changes and counts every event it drops.

Parameters:
N_BTN, 16, number of buttons in each report; range 1..128.
FIFO_DEPTH, 8, event FIFO depth in bytes; must be a power of 2, at least 2.
MODE, 0, 0 = ASCII encoding, 1 = binary encoding.
CHARS, "DULRABSMEFGHIJKL", ASCII press character for each button; byte i is button i, index 0 is the leftmost character.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
rpt_state  in  N_BTN  current button state from report, 1 = pressed
rpt_change  in  N_BTN  change mask from report
rpt_stb  in  1  report strobe, one cycle per report
en_mask  in  N_BTN  per-button event enable
out_data  out  8  event byte at FIFO head
out_valid  out  1  FIFO not empty
out_ack  in  1  pop the head byte; ignored when out_valid=0
ovf_cnt  out  8  count of dropped or coalesced events, saturating
ovf_clr  in  1  synchronous clear of ovf_cnt
busy  out  1  scanner active (pending != 0)

Behaviour:
- Reset (async, rst_n=0): pending=0, snap=0, idx=0, FIFO empty. Outputs: out_valid=0, out_data=0, ovf_cnt=0, busy=0.
- Registers: pending[N_BTN], snap[N_BTN], idx with width clog2(N_BTN), minimum 1 bit.
- Report capture, at the edge where rpt_stb=1:
  - new = rpt_change & en_mask.
  - pending |= new.
  - snap[i] <= rpt_state[i] for each bit set in new.
  - If a bit in new is already pending and is not being emitted this cycle, the events coalesce: the latest state is kept and ovf_cnt increments by 1 per report, not per bit.
- FSM state IDLE (pending==0): idx held at 0. Enters SCAN on the edge after pending becomes non-zero.
- FSM state SCAN, one index per cycle:
  - If pending[idx]=1: emit event(idx, snap[idx]) and clear pending[idx].
  - idx wraps from N_BTN-1 to 0.
  - Return to IDLE when pending becomes 0; idx resets to 0.
  - A new report arriving during SCAN merges into pending; the scan continues from the current idx with no restart.
- Same bit in the same cycle: rpt_stb sets pending[idx] while the scanner clears it. Set wins, snap takes the new value, and the current emit still uses the old snap.
- Event encoding:
  - MODE 0: press emits CHARS[idx]; release emits CHARS[idx] | 8'h20 (lowercase).
  - MODE 1: {snap[idx], idx[6:0]}.
- FIFO:
  - Push and pop both occur on clk edges.
  - out_valid = !empty, asserted directly after the push edge (zero added latency).
  - out_data is the head byte; it is stable while out_valid=1 and out_ack=0.
- FIFO full on emit: if out_ack=1 that cycle, the push succeeds. Otherwise the event is dropped, ovf_cnt increments, and the pending bit still clears.
- ovf_cnt: saturates at 255. If ovf_clr and an increment occur in the same cycle, the clear wins and the result is 0.
- Timing: with rpt_stb sampled at edge E0 while IDLE, the event for button k is pushed at edge E0+1+k at the earliest. A full scan of N_BTN changes takes N_BTN cycles.

Test Plan:
- MODE0, empty FIFO: rpt_change=0x0005, rpt_state=0x0001, en_mask=0xFFFF, hold out_ack=0 -> FIFO holds "D" (0x44) then "l" (0x6C); out_valid rises after E0+1; busy falls after E0+3; ovf_cnt=0.
- Mask: en_mask=0xFFFE, rpt_change=0x0003, rpt_state=0x0003 -> only "U" queued; ovf_cnt=0.
- Overflow, FIFO_DEPTH=8, out_ack=0: rpt_change=0x03FF, rpt_state=0x03FF -> 8 bytes "DULRABSM" queued; ovf_cnt=2; busy returns to 0.
- Coalesce: rpt_change=0xC000 at E0, then rpt_change=0x8000 with rpt_state=0x0000 at E0+2 -> button 15 emits once as release "l"; ovf_cnt=1.
- MODE1 plus handshake: rpt_change=0x0010, rpt_state=0x0010, pulse out_ack while valid -> out_data=0x84; out_valid drops the cycle after the ack; ovf_clr together with a pending increment -> ovf_cnt=0.
- Reset mid-scan: rpt_change=0xFFFF, assert rst_n=0 at E0+3 -> out_valid, busy and ovf_cnt are 0 immediately (async); no events appear after release.
